// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - redirect handshake and predictor update bus
interface branch_resolve_unit_if #(
  parameter int PC_LEN = 32
);
  logic              o_redirect_valid;
  logic [PC_LEN-1:0] o_redirect_pc;
  logic              i_redirect_ready;
  logic [PC_LEN-1:0] o_upd_pc;
  logic [PC_LEN-1:0] o_upd_target;
  logic              o_upd_branch_valid;
  logic              o_upd_taken;
  logic              o_upd_jump;

  modport master (
    output o_redirect_valid, o_redirect_pc,
    output o_upd_pc, o_upd_target, o_upd_branch_valid, o_upd_taken, o_upd_jump,
    input  i_redirect_ready
  );

  modport slave (
    input  o_redirect_valid, o_redirect_pc,
    input  o_upd_pc, o_upd_target, o_upd_branch_valid, o_upd_taken, o_upd_jump,
    output i_redirect_ready
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - carries BTB predictions IF->EX, resolves them, trains and redirects
module branch_resolve_unit #(
  parameter int PC_LEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_if_valid,
  input  logic [PC_LEN-1:0] i_if_pc,
  input  logic              i_bp_valid,
  input  logic              i_bp_taken,
  input  logic [PC_LEN-1:0] i_bp_target,
  input  logic              i_ex_valid,
  input  logic [PC_LEN-1:0] i_ex_pc,
  input  logic              i_ex_is_branch,
  input  logic              i_ex_is_jump,
  input  logic              i_ex_is_compressed,
  input  logic              i_ex_taken,
  input  logic [PC_LEN-1:0] i_ex_target,
  output logic              o_flush,
  output logic [31:0]       o_branch_cnt,
  output logic [31:0]       o_mispredict_cnt,
  branch_resolve_unit_if.master bus
);
  typedef enum logic {ST_RUN, ST_REDIRECT} state_e;

  state_e            state_q, state_d;
  logic              id_valid_q, id_valid_d, id_pred_taken_q, id_pred_taken_d;
  logic [PC_LEN-1:0] id_pc_q, id_pc_d, id_pred_target_q, id_pred_target_d;
  logic              ex_valid_q, ex_valid_d, ex_pred_taken_q, ex_pred_taken_d;
  logic [PC_LEN-1:0] ex_pc_q, ex_pc_d, ex_pred_target_q, ex_pred_target_d;
  logic [PC_LEN-1:0] upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
  logic              upd_branch_valid_q, upd_branch_valid_d, upd_taken_q, upd_taken_d;
  logic              upd_jump_q, upd_jump_d, flush_q, flush_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [PC_LEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]       branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;

  logic              pred_taken, resolve, is_cf, mispredict;
  logic [PC_LEN-1:0] fallthrough, actual_next, pred_next;

  // Metadata only counts as the EX prediction if it belongs to the same PC.
  assign pred_taken  = ex_valid_q && (ex_pc_q == i_ex_pc) && ex_pred_taken_q;
  assign resolve     = i_ex_valid && !i_stall && (state_q == ST_RUN);
  assign is_cf       = i_ex_is_branch || i_ex_is_jump;
  assign fallthrough = i_ex_pc + (i_ex_is_compressed ? PC_LEN'(2) : PC_LEN'(4));
  assign actual_next = (i_ex_is_jump || (i_ex_is_branch && i_ex_taken)) ? i_ex_target : fallthrough;
  assign pred_next   = pred_taken ? ex_pred_target_q : fallthrough;
  assign mispredict  = resolve && (pred_next != actual_next);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q            <= ST_RUN;
      id_valid_q         <= 1'b0;
      id_pc_q            <= '0;
      id_pred_taken_q    <= 1'b0;
      id_pred_target_q   <= '0;
      ex_valid_q         <= 1'b0;
      ex_pc_q            <= '0;
      ex_pred_taken_q    <= 1'b0;
      ex_pred_target_q   <= '0;
      upd_pc_q           <= '0;
      upd_target_q       <= '0;
      upd_branch_valid_q <= 1'b0;
      upd_taken_q        <= 1'b0;
      upd_jump_q         <= 1'b0;
      flush_q            <= 1'b0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_cnt_q       <= '0;
      mispredict_cnt_q   <= '0;
    end else begin
      state_q            <= state_d;
      id_valid_q         <= id_valid_d;
      id_pc_q            <= id_pc_d;
      id_pred_taken_q    <= id_pred_taken_d;
      id_pred_target_q   <= id_pred_target_d;
      ex_valid_q         <= ex_valid_d;
      ex_pc_q            <= ex_pc_d;
      ex_pred_taken_q    <= ex_pred_taken_d;
      ex_pred_target_q   <= ex_pred_target_d;
      upd_pc_q           <= upd_pc_d;
      upd_target_q       <= upd_target_d;
      upd_branch_valid_q <= upd_branch_valid_d;
      upd_taken_q        <= upd_taken_d;
      upd_jump_q         <= upd_jump_d;
      flush_q            <= flush_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_cnt_q       <= branch_cnt_d;
      mispredict_cnt_q   <= mispredict_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mispredict) state_d = ST_REDIRECT;
      ST_REDIRECT: if (redirect_valid_q && bus.i_redirect_ready) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_comb begin
    flush_d          = 1'b0;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = actual_next;
        end
      end
      ST_REDIRECT: if (redirect_valid_q && bus.i_redirect_ready) redirect_valid_d = 1'b0;
      default: ;
    endcase

    // Jump wins when both decode flags are set.
    upd_jump_d         = resolve && i_ex_is_jump;
    upd_branch_valid_d = resolve && i_ex_is_branch && !i_ex_is_jump;
    upd_taken_d        = upd_jump_d || (upd_branch_valid_d && i_ex_taken);
    upd_pc_d           = (resolve && is_cf) ? i_ex_pc : upd_pc_q;
    upd_target_d       = (resolve && is_cf) ? i_ex_target : upd_target_q;

    id_valid_d       = id_valid_q;
    id_pc_d          = id_pc_q;
    id_pred_taken_d  = id_pred_taken_q;
    id_pred_target_d = id_pred_target_q;
    ex_valid_d       = ex_valid_q;
    ex_pc_d          = ex_pc_q;
    ex_pred_taken_d  = ex_pred_taken_q;
    ex_pred_target_d = ex_pred_target_q;
    if (!i_stall) begin
      id_valid_d       = i_if_valid;
      id_pc_d          = i_if_pc;
      id_pred_taken_d  = i_bp_valid && i_bp_taken;
      id_pred_target_d = i_bp_target;
      ex_valid_d       = id_valid_q;
      ex_pc_d          = id_pc_q;
      ex_pred_taken_d  = id_pred_taken_q;
      ex_pred_target_d = id_pred_target_q;
    end
    // Everything in flight is wrong-path from the mispredict until the redirect is taken.
    if (mispredict || state_q == ST_REDIRECT) begin
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
    end

    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (resolve && is_cf && branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispredict && mispredict_cnt_q != 32'hFFFF_FFFF) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  assign o_flush                = flush_q;
  assign o_branch_cnt           = branch_cnt_q;
  assign o_mispredict_cnt       = mispredict_cnt_q;
  assign bus.o_redirect_valid   = redirect_valid_q;
  assign bus.o_redirect_pc      = redirect_pc_q;
  assign bus.o_upd_pc           = upd_pc_q;
  assign bus.o_upd_target       = upd_target_q;
  assign bus.o_upd_branch_valid = upd_branch_valid_q;
  assign bus.o_upd_taken        = upd_taken_q;
  assign bus.o_upd_jump         = upd_jump_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
  logic        i_clk, i_rst_n, i_stall;
  logic        i_if_valid, i_bp_valid, i_bp_taken;
  logic [31:0] i_if_pc, i_bp_target;
  logic        i_ex_valid, i_ex_is_branch, i_ex_is_jump, i_ex_is_compressed, i_ex_taken;
  logic [31:0] i_ex_pc, i_ex_target;
  logic        o_flush;
  logic [31:0] o_branch_cnt, o_mispredict_cnt;

  branch_resolve_unit_if #(.PC_LEN(32)) bus ();

  branch_resolve_unit #(.PC_LEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
    .i_if_valid(i_if_valid), .i_if_pc(i_if_pc),
    .i_bp_valid(i_bp_valid), .i_bp_taken(i_bp_taken), .i_bp_target(i_bp_target),
    .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_ex_is_branch(i_ex_is_branch),
    .i_ex_is_jump(i_ex_is_jump), .i_ex_is_compressed(i_ex_is_compressed),
    .i_ex_taken(i_ex_taken), .i_ex_target(i_ex_target),
    .o_flush(o_flush), .o_branch_cnt(o_branch_cnt), .o_mispredict_cnt(o_mispredict_cnt),
    .bus(bus.master)
  );

  typedef struct {
    logic        br, jmp, taken, mis;
    logic [31:0] pc, tgt, redir;
  } evt_t;

  evt_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_bcnt = 0, exp_mcnt = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and retire any update/flush the DUT produced against the scoreboard.
  task automatic step();
    evt_t e;
    @(posedge i_clk);
    #1;
    if (o_flush || bus.o_upd_branch_valid || bus.o_upd_jump) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = sb.pop_front();
        check("upd_branch_valid", bus.o_upd_branch_valid, e.br & ~e.jmp);
        check("upd_jump", bus.o_upd_jump, e.jmp);
        check("flush", o_flush, e.mis);
        if (e.br || e.jmp) begin
          check("upd_taken", bus.o_upd_taken, e.jmp ? 1 : e.taken);
          check("upd_pc", bus.o_upd_pc, e.pc);
          check("upd_target", bus.o_upd_target, e.tgt);
          if (exp_bcnt != 32'hFFFF_FFFF) exp_bcnt++;
        end
        if (e.mis) begin
          check("redirect_valid", bus.o_redirect_valid, 1);
          check("redirect_pc", bus.o_redirect_pc, e.redir);
          if (exp_mcnt != 32'hFFFF_FFFF) exp_mcnt++;
        end
      end
    end
    check("branch_cnt", o_branch_cnt, exp_bcnt);
    check("mispredict_cnt", o_mispredict_cnt, exp_mcnt);
  endtask

  task automatic issue(input logic [31:0] pc, input logic bv, input logic bt, input logic [31:0] btgt);
    i_if_valid = 1; i_if_pc = pc; i_bp_valid = bv; i_bp_taken = bt; i_bp_target = btgt;
    step();
    i_if_valid = 0; i_bp_valid = 0; i_bp_taken = 0;
    step();
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic br, input logic jmp, input logic cmp,
                        input logic tk, input logic [31:0] tgt);
    i_ex_valid = 1; i_ex_pc = pc; i_ex_is_branch = br; i_ex_is_jump = jmp;
    i_ex_is_compressed = cmp; i_ex_taken = tk; i_ex_target = tgt;
  endtask

  task automatic ex_go(input logic [31:0] pc, input logic br, input logic jmp, input logic cmp,
                       input logic tk, input logic [31:0] tgt, input logic mis, input logic [31:0] redir);
    evt_t e;
    set_ex(pc, br, jmp, cmp, tk, tgt);
    e.br = br; e.jmp = jmp; e.taken = tk; e.mis = mis; e.pc = pc; e.tgt = tgt; e.redir = redir;
    if (br || jmp || mis) sb.push_back(e);
    step();
    i_ex_valid = 0;
    check("event_missing", sb.size(), 0);
  endtask

  task automatic redirect_wait(input int n_low, input logic [31:0] pc);
    int hi = 0;
    bus.i_redirect_ready = 0;
    for (int k = 0; k < n_low; k++) begin
      if (bus.o_redirect_valid) hi++;
      check("redirect_pc_hold", bus.o_redirect_pc, pc);
      step();
    end
    bus.i_redirect_ready = 1;
    if (bus.o_redirect_valid) hi++;
    step();
    check("redirect_hold_cycles", hi, n_low + 1);
    check("redirect_dropped", bus.o_redirect_valid, 0);
    bus.i_redirect_ready = 0;
  endtask

  initial begin
    i_rst_n = 0; i_stall = 0; i_if_valid = 0; i_if_pc = 0; i_bp_valid = 0; i_bp_taken = 0;
    i_bp_target = 0; i_ex_valid = 0; i_ex_pc = 0; i_ex_is_branch = 0; i_ex_is_jump = 0;
    i_ex_is_compressed = 0; i_ex_taken = 0; i_ex_target = 0; bus.i_redirect_ready = 0;
    step();
    step();
    check("rst_flush", o_flush, 0);
    check("rst_redirect_valid", bus.o_redirect_valid, 0);
    check("rst_redirect_pc", bus.o_redirect_pc, 0);
    check("rst_upd_branch_valid", bus.o_upd_branch_valid, 0);
    check("rst_upd_jump", bus.o_upd_jump, 0);
    check("rst_upd_pc", bus.o_upd_pc, 0);
    i_rst_n = 1;
    step();

    // Correctly predicted taken branch
    issue(32'h100, 1, 1, 32'h200);
    ex_go(32'h100, 1, 0, 0, 1, 32'h200, 0, 0);
    check("t1_branch_cnt", o_branch_cnt, 1);
    check("t1_mispredict_cnt", o_mispredict_cnt, 0);

    // BTB miss, resolves taken: redirect held through 3 cycles of ready low
    issue(32'h100, 0, 0, 32'h0);
    ex_go(32'h100, 1, 0, 0, 1, 32'h180, 1, 32'h180);
    redirect_wait(3, 32'h180);

    // Compressed branch predicted taken, falls through; ready high already (RUN ignores it)
    issue(32'h102, 1, 1, 32'h40);
    bus.i_redirect_ready = 1;
    ex_go(32'h102, 1, 0, 1, 0, 32'h40, 1, 32'h104);
    redirect_wait(0, 32'h104);

    // JALR wrong target; younger EX instruction during REDIRECT is ignored; stall has no effect
    issue(32'h300, 1, 1, 32'h500);
    ex_go(32'h300, 0, 1, 0, 1, 32'h600, 1, 32'h600);
    set_ex(32'h304, 1, 0, 0, 1, 32'h700);
    step();
    i_ex_valid = 0;
    i_stall = 1;
    redirect_wait(1, 32'h600);
    i_stall = 0;
    check("t4_branch_cnt", o_branch_cnt, 4);
    check("t4_mispredict_cnt", o_mispredict_cnt, 3);

    // Non-branch predicted taken: redirect to fall-through, no training
    issue(32'h400, 1, 1, 32'h800);
    ex_go(32'h400, 0, 0, 0, 0, 32'h0, 1, 32'h404);
    redirect_wait(0, 32'h404);

    // Back-to-back correct resolutions
    i_if_valid = 1; i_if_pc = 32'h500; i_bp_valid = 0; i_bp_taken = 0;
    step();
    i_if_pc = 32'h504; i_bp_valid = 1; i_bp_taken = 1; i_bp_target = 32'h900;
    step();
    i_if_valid = 0; i_bp_valid = 0; i_bp_taken = 0;
    ex_go(32'h500, 1, 0, 0, 0, 32'h540, 0, 0);
    ex_go(32'h504, 1, 1, 0, 1, 32'h900, 0, 0);
    step();
    check("b2b_pulse_ended", bus.o_upd_jump, 0);

    // Stall with branch in EX; a fetch during the stall must not disturb metadata
    issue(32'h600, 1, 1, 32'h700);
    set_ex(32'h600, 1, 0, 0, 1, 32'h700);
    i_stall = 1;
    i_if_valid = 1; i_if_pc = 32'h999; i_bp_valid = 1; i_bp_taken = 0;
    for (int k = 0; k < 5; k++) step();
    i_if_valid = 0; i_bp_valid = 0;
    i_stall = 0;
    ex_go(32'h600, 1, 0, 0, 1, 32'h700, 0, 0);
    check("stall_branch_cnt", o_branch_cnt, 7);
    check("stall_mispredict_cnt", o_mispredict_cnt, 4);

    // Mispredict counter saturation
    force dut.mispredict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_cnt_q;
    exp_mcnt = 32'hFFFF_FFFE;
    issue(32'h700, 0, 0, 32'h0);
    ex_go(32'h700, 1, 0, 0, 1, 32'h7A0, 1, 32'h7A0);
    redirect_wait(0, 32'h7A0);
    issue(32'h710, 0, 0, 32'h0);
    ex_go(32'h710, 1, 0, 0, 1, 32'h7B0, 1, 32'h7B0);
    check("mcnt_saturated", o_mispredict_cnt, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of REDIRECT
    check("pre_reset_redirect_valid", bus.o_redirect_valid, 1);
    #2 i_rst_n = 0;
    #1;
    check("async_rst_redirect_valid", bus.o_redirect_valid, 0);
    check("async_rst_redirect_pc", bus.o_redirect_pc, 0);
    check("async_rst_upd_branch_valid", bus.o_upd_branch_valid, 0);
    check("async_rst_mispredict_cnt", o_mispredict_cnt, 0);
    check("async_rst_branch_cnt", o_branch_cnt, 0);
    sb.delete();
    exp_bcnt = 0;
    exp_mcnt = 0;
    step();
    i_rst_n = 1;
    step();

    // Back in RUN after reset: a correct prediction trains without redirect
    issue(32'h800, 1, 1, 32'h880);
    ex_go(32'h800, 1, 0, 0, 1, 32'h880, 0, 0);
    check("post_rst_flush", o_flush, 0);
    check("post_rst_branch_cnt", o_branch_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Closes the branch-prediction loop. It carries each fetch's BTB prediction alongside the instruction from IF to EX, and compares it with the resolved outcome in EX. On each resolution it drives the predictor's training/update port and, on a mispredict, flushes the front end and issues a redirect PC through a valid/ready handshake. It also keeps saturating branch and mispredict counters for performance monitoring.

## Interface
- PC_LEN, 32, PC/target width
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_stall  in  1  pipeline hold; when 1, metadata and EX resolution do not advance
- i_if_valid  in  1  a fetched instruction enters ID this cycle
- i_if_pc  in  PC_LEN  PC of the fetched instruction
- i_bp_valid  in  1  BTB tag hit for i_if_pc
- i_bp_taken  in  1  BTB predicts taken (counter MSB)
- i_bp_target  in  PC_LEN  BTB predicted target
- i_ex_valid  in  1  live instruction in EX
- i_ex_pc  in  PC_LEN  PC of the EX instruction
- i_ex_is_branch  in  1  conditional branch
- i_ex_is_jump  in  1  JAL/JALR (or C.J/C.JAL/C.JR/C.JALR)
- i_ex_is_compressed  in  1  16-bit instruction; fall-through is PC+2, else PC+4
- i_ex_taken  in  1  resolved branch direction
- i_ex_target  in  PC_LEN  resolved target
- o_upd_pc  out  PC_LEN  predictor write PC
- o_upd_target  out  PC_LEN  predictor write target
- o_upd_branch_valid  out  1  conditional-branch update pulse
- o_upd_taken  out  1  resolved direction for the update
- o_upd_jump  out  1  jump update pulse
- o_flush  out  1  one-cycle kill of IF/ID
- o_redirect_valid  out  1  redirect request
- o_redirect_pc  out  PC_LEN  correct next PC
- i_redirect_ready  in  1  fetch accepts redirect
- o_branch_cnt  out  32  resolved branches plus jumps, saturating
- o_mispredict_cnt  out  32  mispredicts, saturating

## Operation
- Metadata pipe has two registers, ID and EX. Each holds {valid, pc, pred_taken = i_bp_valid & i_bp_taken, pred_target}.
- When i_stall = 0: ID <= IF inputs (valid = i_if_valid), and EX <= ID.
- When i_stall = 1: both registers hold.
- Prediction used in EX is the EX metadata if EX.valid and EX.pc == i_ex_pc. Otherwise the prediction is treated as not-taken.
- A resolution event is i_ex_valid & !i_stall & state == RUN.
- fallthrough = i_ex_pc + (i_ex_is_compressed ? 2 : 4), modulo 2^PC_LEN.
- actual_next = (i_ex_is_jump | (i_ex_is_branch & i_ex_taken)) ? i_ex_target : fallthrough.
- pred_next = pred_taken ? pred_target : fallthrough.
- mispredict = resolution event & (pred_next != actual_next). This also covers a non-branch instruction predicted taken, which redirects to fallthrough.
- Update port, registered and driven for one cycle after the resolution event:
  - Branch: o_upd_branch_valid = 1, o_upd_taken = i_ex_taken.
  - Jump: o_upd_jump = 1, o_upd_taken = 1.
  - Non-branch: no update.
  - If both i_ex_is_branch and i_ex_is_jump are set, jump wins.
- FSM states:
  - RUN: on mispredict, register o_flush = 1 (one cycle), o_redirect_valid = 1, o_redirect_pc = actual_next, clear both metadata valids, and go to REDIRECT.
  - REDIRECT: hold o_redirect_valid and o_redirect_pc. Ignore EX resolutions (wrong path): no updates, no counts. Force metadata valids to 0. When o_redirect_valid & i_redirect_ready, drop o_redirect_valid next cycle and return to RUN.
- Counters:
  - o_branch_cnt increments on each resolution with branch or jump.
  - o_mispredict_cnt increments on each mispredict.
  - Both stick at 0xFFFF_FFFF.

## Timing
- Reset values: all outputs 0, state RUN, metadata valids 0, counters 0.
- Resolution in cycle N gives the update, flush, redirect and counter changes at cycle N+1 (all outputs registered).
- o_flush is high for exactly one cycle per mispredict.
- o_redirect_valid stays high from N+1 until the cycle i_redirect_ready is sampled high, inclusive. Ready already high at N+1 gives a one-cycle redirect.
- i_redirect_ready while o_redirect_valid = 0 is ignored.
- i_stall high during REDIRECT has no effect on the handshake.
- Reset asserted mid-REDIRECT drops o_redirect_valid immediately (asynchronous) and returns the FSM to RUN.
- Back-to-back resolutions in RUN produce back-to-back update pulses.

## Test plan
- Branch at 0x100, predicted taken to 0x200 via BTB hit; EX resolves taken to 0x200. Expect: o_upd_branch_valid = 1 and o_upd_taken = 1 at N+1, no flush, o_branch_cnt = 1, o_mispredict_cnt = 0.
- BTB miss on branch 0x100 (4-byte); EX resolves taken to 0x180. Expect: o_flush pulse, o_redirect_pc = 0x180, o_mispredict_cnt = 1. With i_redirect_ready low for 3 cycles, o_redirect_valid is held 4 cycles.
- Compressed branch 0x102, predicted taken to 0x40, resolves not-taken. Expect: redirect to 0x104, o_upd_taken = 0.
- JALR at 0x300 predicted to 0x500, resolves 0x600. Expect: o_upd_jump = 1, o_upd_target = 0x600, redirect 0x600. A younger EX instruction while in REDIRECT produces no update or count.
- i_stall held 5 cycles with a branch in EX. Expect: exactly one update and one count after the stall releases; metadata is not lost.
- Preload o_mispredict_cnt near saturation (force), then mispredict twice. Expect: the counter stays at 0xFFFF_FFFF. Reset during REDIRECT clears all outputs within the same cycle.
